switch_output_scheduler: RTL and testbench
==========================================

# switch_output_scheduler

Packet-level crossbar scheduler for the 4-port switch. Each input port presents a packet head (valid + 2-bit target) and the scheduler grants each output port to at most one input at a time, round-robin among contenders, holding the grant for a whole packet until its last beat transfers. It sits between the input-port packet buffers and the crossbar mux, driving the mux selects and the per-input grant lines.

## Interface
- `TIMEOUT`, 256: cycles without a transfer on a busy output before the grant is forcibly released (≥2).
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  4  input i has a packet head waiting.
- `req_target`  in  8  bits [2i+1:2i] = target output of input i's head packet.
- `beat_valid`  in  4  input i presents a data beat this cycle.
- `beat_last`  in  4  input i's beat is the packet's last.
- `out_ready`  in  4  output o accepts a beat this cycle.
- `gnt`  out  4  input i currently owns an output.
- `out_sel`  out  8  bits [2o+1:2o] = input index driving output o (valid only while `out_busy[o]`).
- `out_busy`  out  4  output o is allocated.
- `timeout`  out  4  one-cycle pulse: output o's grant was released by watchdog.
- `err_nogrant`  out  4  sticky: input i asserted `beat_valid` while not granted.

## Operation
- One independent FSM per output o: IDLE, BUSY.
- IDLE: candidates = inputs i with `req_valid[i]`, `req_target[i]==o`, `gnt[i]==0`. If any, pick first candidate searching upward (mod 4) from `ptr[o]+1`; register: state->BUSY, `out_sel[o]`=i, `gnt[i]`=1, `ptr[o]`=i. No candidate: stay IDLE, `ptr` unchanged.
- Transfer on output o = BUSY and `beat_valid[sel] & out_ready[o]`.
- BUSY -> IDLE when transfer with `beat_last[sel]`; `gnt[sel]` and `out_busy[o]` clear next edge.
- BUSY -> IDLE on watchdog: counter cleared on entry to BUSY and on each transfer, increments otherwise; when it reaches `TIMEOUT-1` without a transfer, release as above and pulse `timeout[o]` for one cycle.
- An input is a candidate for only one output per cycle (its single target), so `gnt` never double-allocates; each input owned by ≤1 output.
- `req_valid`/`req_target` are ignored while the input is granted; deasserting `req_valid` mid-packet does not release the grant.
- `err_nogrant[i]` sets on `beat_valid[i] & ~gnt[i]`; cleared only by reset.
- Invariants (bench assertions): `out_sel` values of busy outputs are distinct; `gnt` = OR over busy outputs of one-hot(`out_sel`).

## Timing
- Reset (async assert, sync release): all FSMs IDLE, `gnt`=0, `out_sel`=0, `out_busy`=0, `timeout`=0, `err_nogrant`=0, all `ptr`=3 (input 0 wins first), watchdog counters 0.
- Grant latency: `req_valid` sampled at edge N -> `gnt`/`out_busy`/`out_sel` high after edge N (visible cycle N+1); earliest beat transfer in cycle N+1.
- Single-beat packet: transfer with `beat_last` in cycle N+1 -> released after edge N+1.
- Released output is IDLE for at least one cycle before regrant (the released input may win again only if no other candidate, per pointer).
- Different outputs grant/release in the same cycle independently.
- Reset asserted mid-packet: grants drop immediately; no partial-packet state retained.
- Release and watchdog coinciding (last beat transfers on the expiry cycle): treated as normal release, no `timeout` pulse.

## Test plan
- Reset, then input 2 requests target 1 -> one cycle later `gnt`=0100, `out_busy`=0010, `out_sel[3:2]`=2; 4-beat packet with `out_ready`=1 -> release after 4th beat edge.
- Inputs 0,1,3 all request output 0 continuously, 1-beat packets -> grant order 0,1,3,0,1,3 with one idle cycle between grants.
- Inputs 0->2, 1->3, 2->0, 3->1 simultaneously -> all four granted same cycle, `out_busy`=1111, `out_sel`=0x4E (o0←2,o1←3,o2←0,o3←1).
- Input 1 granted to output 0, `out_ready[0]`=0 for TIMEOUT=8 cycles -> `timeout[0]` pulses once, `gnt[1]`=0 next cycle; `out_ready` toggling 0/1 with transfers never times out.
- Input 3 drives `beat_valid` while ungranted -> `err_nogrant`=1000 sticky until `rst_n` low; `rst_n` low mid-packet -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/switch_output_scheduler.sv
// switch_output_scheduler
// Packet-level crossbar scheduler for a 4-port switch. Each output runs its
// own IDLE/BUSY FSM. An idle output grants itself round-robin to one waiting
// input and holds that grant until the packet's last beat transfers, or until
// a watchdog sees no transfer for TIMEOUT cycles.
module switch_output_scheduler #(
    parameter int TIMEOUT = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req_valid,
    input  logic [7:0] req_target,
    input  logic [3:0] beat_valid,
    input  logic [3:0] beat_last,
    input  logic [3:0] out_ready,
    output logic [3:0] gnt,
    output logic [7:0] out_sel,
    output logic [3:0] out_busy,
    output logic [3:0] timeout,
    output logic [3:0] err_nogrant
);

    localparam int              CW      = $clog2(TIMEOUT);
    localparam logic [CW-1:0]   CNT_MAX = CW'(TIMEOUT - 1);

    localparam logic [0:0]      ST_IDLE = 1'b0;
    localparam logic [0:0]      ST_BUSY = 1'b1;

    // Per-output state
    logic [0:0]    r_state [4];
    logic [1:0]    r_sel   [4];
    logic [1:0]    r_ptr   [4];
    logic [CW-1:0] r_cnt   [4];
    logic [3:0]    r_timeout;
    logic [3:0]    r_err;

    // Derived per-cycle decisions
    logic [3:0]    w_gnt;
    logic [3:0]    w_cand  [4];
    logic [3:0]    w_found;
    logic [1:0]    w_pick  [4];
    logic [3:0]    w_xfer;
    logic [3:0]    w_last;
    logic [3:0]    w_expire;

    // Input ownership decoded from the busy outputs' selects.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        w_gnt = '0;
        for (int o = 0; o < 4; o++) begin
            if (r_state[o] == ST_BUSY) begin
                w_gnt[r_sel[o]] = 1'b1;
            end
        end
    end

    // Candidates: waiting, targeting this output, and not already owned.
    always_comb begin
        for (int o = 0; o < 4; o++) begin
            w_cand[o] = '0;
            for (int i = 0; i < 4; i++) begin
                w_cand[o][i] = req_valid[i] & ~w_gnt[i] &
                               (req_target[2*i +: 2] == 2'(o));
            end
        end
    end

    // Round-robin pick: first candidate above the pointer, wrapping mod 4.
    // Scanning from the farthest position down lets the nearest one win.
    always_comb begin
        for (int o = 0; o < 4; o++) begin
            w_found[o] = 1'b0;
            w_pick[o]  = '0;
            for (int k = 4; k >= 1; k--) begin
                if (w_cand[o][r_ptr[o] + 2'(k)]) begin
                    w_found[o] = 1'b1;
                    w_pick[o]  = r_ptr[o] + 2'(k);
                end
            end
        end
    end

    // Beat transfer, last-beat and watchdog-expiry conditions per output.
    always_comb begin
        for (int o = 0; o < 4; o++) begin
            w_xfer[o]   = (r_state[o] == ST_BUSY) & beat_valid[r_sel[o]] & out_ready[o];
            w_last[o]   = beat_last[r_sel[o]];
            w_expire[o] = (r_cnt[o] == CNT_MAX);
        end
    end

    // Per-output FSM, round-robin pointer and watchdog counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: these small per-output arrays are control state, so every
            // entry is reset; the pointer starts at 3 so input 0 wins first.
            for (int o = 0; o < 4; o++) begin
                r_state[o] <= ST_IDLE;
                r_sel[o]   <= '0;
                r_ptr[o]   <= 2'd3;
                r_cnt[o]   <= '0;
            end
            r_timeout <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every output's update based
            // on the same pre-edge state, so the four FSMs stay independent.
            for (int o = 0; o < 4; o++) begin
                r_timeout[o] <= 1'b0;
                if (r_state[o] == ST_IDLE) begin
                    if (w_found[o]) begin
                        r_state[o] <= ST_BUSY;
                        r_sel[o]   <= w_pick[o];
                        r_ptr[o]   <= w_pick[o];
                        r_cnt[o]   <= '0;
                    end
                end else begin
                    // A transfer wins over expiry: a last beat on the expiry
                    // cycle is an ordinary release with no timeout pulse.
                    if (w_xfer[o]) begin
                        r_cnt[o] <= '0;
                        if (w_last[o]) begin
                            r_state[o] <= ST_IDLE;
                        end
                    end else if (w_expire[o]) begin
                        r_state[o]   <= ST_IDLE;
                        r_cnt[o]     <= '0;
                        r_timeout[o] <= 1'b1;
                    end else begin
                        r_cnt[o] <= r_cnt[o] + 1'b1;
                    end
                end
            end
        end
    end

    // Sticky flag: a beat offered by an input that owns no output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= '0;
        end else begin
            r_err <= r_err | (beat_valid & ~w_gnt);
        end
    end

    // Output packing.
    always_comb begin
        for (int o = 0; o < 4; o++) begin
            out_busy[o]       = (r_state[o] == ST_BUSY);
            out_sel[2*o +: 2] = r_sel[o];
        end
    end

    assign gnt         = w_gnt;
    assign timeout     = r_timeout;
    assign err_nogrant = r_err;

endmodule

// File: tb/tb_switch_output_scheduler.sv
// Testbench for switch_output_scheduler: directed scenarios plus randomized
// traffic, checked against an owner-per-output reference model through a
// snapshot queue and a grant-event scoreboard.
module tb_switch_output_scheduler;

    localparam int T = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req_valid, beat_valid, beat_last, out_ready;
    logic [7:0] req_target;
    logic [3:0] gnt, out_busy, timeout, err_nogrant;
    logic [7:0] out_sel;

    switch_output_scheduler #(.TIMEOUT(T)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_target  (req_target),
        .beat_valid  (beat_valid),
        .beat_last   (beat_last),
        .out_ready   (out_ready),
        .gnt         (gnt),
        .out_sel     (out_sel),
        .out_busy    (out_busy),
        .timeout     (timeout),
        .err_nogrant (err_nogrant)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_owner[o] is the input holding output o, or -1 when the output is free.
    int         m_owner [4];
    int         m_ptr   [4];
    int         m_idle  [4];
    logic [3:0] m_to;
    logic [3:0] m_err;

    typedef struct {
        int         due;
        logic [3:0] gnt;
        logic [3:0] busy;
        logic [7:0] sel;
        logic [3:0] to;
        logic [3:0] err;
    } snap_t;

    snap_t exp_q [$];
    int    grant_q [4][$];

    function automatic logic [3:0] m_gnt();
        logic [3:0] g = '0;
        for (int o = 0; o < 4; o++) if (m_owner[o] >= 0) g[m_owner[o]] = 1'b1;
        return g;
    endfunction

    task automatic model_reset();
        for (int o = 0; o < 4; o++) begin
            m_owner[o] = -1;
            m_ptr[o]   = 3;
            m_idle[o]  = 0;
            grant_q[o].delete();
        end
        m_to  = '0;
        m_err = '0;
        exp_q.delete();
    endtask

    // Advance the model by one clock edge using the inputs now being driven.
    task automatic model_step();
        logic [3:0] cg = m_gnt();
        int         n_owner [4];
        snap_t      s;
        for (int o = 0; o < 4; o++) begin
            n_owner[o] = m_owner[o];
            m_to[o]    = 1'b0;
            if (m_owner[o] < 0) begin
                for (int k = 1; k <= 4; k++) begin
                    int i = (m_ptr[o] + k) % 4;
                    if (n_owner[o] < 0 && req_valid[i] && !cg[i] &&
                        req_target[2*i +: 2] == 2'(o)) begin
                        n_owner[o] = i;
                        m_ptr[o]   = i;
                        m_idle[o]  = 0;
                        grant_q[o].push_back(i);
                    end
                end
            end else begin
                int src = m_owner[o];
                if (beat_valid[src] && out_ready[o]) begin
                    m_idle[o] = 0;
                    if (beat_last[src]) n_owner[o] = -1;
                end else if (m_idle[o] == T - 1) begin
                    n_owner[o] = -1;
                    m_to[o]    = 1'b1;
                    m_idle[o]  = 0;
                end else begin
                    m_idle[o]++;
                end
            end
        end
        m_err = m_err | (beat_valid & ~cg);
        for (int o = 0; o < 4; o++) m_owner[o] = n_owner[o];
        s.due  = cyc + 1;
        s.gnt  = m_gnt();
        s.busy = '0;
        s.sel  = '0;
        for (int o = 0; o < 4; o++) begin
            if (m_owner[o] >= 0) begin
                s.busy[o]       = 1'b1;
                s.sel[2*o +: 2] = 2'(m_owner[o]);
            end
        end
        s.to  = m_to;
        s.err = m_err;
        exp_q.push_back(s);
    endtask

    // ---------------- monitor ----------------
    logic [3:0] prev_busy = '0;
    snap_t      e;
    logic [3:0] oh;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                prev_busy = '0;
                continue;
            end
            while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                e = exp_q.pop_front();
                check("gnt",         gnt,                  e.gnt);
                check("out_busy",    out_busy,             e.busy);
                check("out_sel",     out_sel & {{2{e.busy[3]}}, {2{e.busy[2]}},
                                                {2{e.busy[1]}}, {2{e.busy[0]}}}, e.sel);
                check("timeout",     timeout,              e.to);
                check("err_nogrant", err_nogrant,          e.err);
            end
            oh = '0;
            for (int o = 0; o < 4; o++) if (out_busy[o]) oh[out_sel[2*o +: 2]] = 1'b1;
            check("inv_distinct", $countones(oh), $countones(out_busy));
            check("inv_gnt",      gnt,            oh);
            for (int o = 0; o < 4; o++) begin
                if (out_busy[o] && !prev_busy[o]) begin
                    if (grant_q[o].size() == 0) check("grant_unexpected", 1, 0);
                    else check("grant_sel", out_sel[2*o +: 2], grant_q[o].pop_front());
                end
            end
            prev_busy = out_busy;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic [3:0] rv, input logic [7:0] tg,
                        input logic [3:0] bv, input logic [3:0] bl, input logic [3:0] rdy);
        req_valid  = rv;
        req_target = tg;
        beat_valid = bv;
        beat_last  = bl;
        out_ready  = rdy;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid  = '0;
        req_target = '0;
        beat_valid = '0;
        beat_last  = '0;
        out_ready  = '0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_gnt"},  gnt,         4'h0);
        check({tag, "_busy"}, out_busy,    4'h0);
        check({tag, "_sel"},  out_sel,     8'h00);
        check({tag, "_to"},   timeout,     4'h0);
        check({tag, "_err"},  err_nogrant, 4'h0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        #1;
        check_reset_state(tag);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    int         order [$];
    logic       pb;
    logic [3:0] g, rv, bv, bl, rdy;
    int         exp_order [6] = '{0, 1, 3, 0, 1, 3};

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst_n = 1'b1;

        // Input 2 -> output 1, 4-beat packet.
        step(4'b0100, 8'h10, 4'b0000, 4'b0000, 4'hF);
        check("t1_gnt",  gnt,          4'b0100);
        check("t1_busy", out_busy,     4'b0010);
        check("t1_sel",  out_sel[3:2], 2'd2);
        for (int b = 0; b < 4; b++) begin
            step(4'b0000, 8'h10, 4'b0100, (b == 3) ? 4'b0100 : 4'b0000, 4'hF);
            check("t1_busy_beat", out_busy, (b == 3) ? 4'b0000 : 4'b0010);
        end
        check("t1_gnt_rel", gnt, 4'b0000);
        step(4'h0, 8'h00, 4'h0, 4'h0, 4'hF);

        // Inputs 0,1,3 contend for output 0 with 1-beat packets.
        pb = 1'b0;
        for (int n = 0; n < 12; n++) begin
            g = m_gnt();
            step(4'b1011, 8'h00, g, g, 4'hF);
            if (out_busy[0] && !pb) order.push_back(int'(out_sel[1:0]));
            pb = out_busy[0];
        end
        check("t2_count", order.size(), 6);
        for (int n = 0; n < 6 && n < order.size(); n++) check("t2_order", order[n], exp_order[n]);
        step(4'h0, 8'h00, 4'h0, 4'h0, 4'hF);

        // All four inputs to distinct outputs at once.
        step(4'hF, 8'h4E, 4'h0, 4'h0, 4'hF);
        check("t3_busy", out_busy, 4'hF);
        check("t3_gnt",  gnt,      4'hF);
        check("t3_sel",  out_sel,  8'h4E);
        step(4'h0, 8'h4E, 4'hF, 4'hF, 4'hF);
        check("t3_rel", out_busy, 4'h0);
        step(4'h0, 8'h00, 4'h0, 4'h0, 4'hF);

        // Watchdog: input 1 on output 0 with output 0 stalled.
        step(4'b0010, 8'h00, 4'h0, 4'h0, 4'hF);
        check("t4_gnt", gnt, 4'b0010);
        for (int k = 1; k <= T; k++) begin
            step(4'h0, 8'h00, 4'b0010, 4'h0, 4'b1110);
            if (k < T) check("t4_wait", {timeout[0], out_busy[0]}, 2'b01);
        end
        check("t4_pulse",   timeout[0], 1'b1);
        check("t4_gnt_rel", gnt[1],     1'b0);
        step(4'h0, 8'h00, 4'h0, 4'h0, 4'hF);
        check("t4_pulse_end", timeout, 4'h0);

        // Toggling ready with transfers keeps the grant alive.
        step(4'b0010, 8'h00, 4'h0, 4'h0, 4'hF);
        for (int k = 0; k < 30; k++) begin
            step(4'h0, 8'h00, 4'b0010, 4'h0, {3'b111, 1'(k % 2)});
            check("t4_no_to", timeout[0], 1'b0);
        end
        check("t4_still_busy", out_busy[0], 1'b1);
        step(4'h0, 8'h00, 4'b0010, 4'b0010, 4'hF);
        step(4'h0, 8'h00, 4'h0, 4'h0, 4'hF);

        // Rogue beat from ungranted input 3.
        step(4'h0, 8'h00, 4'b1000, 4'h0, 4'hF);
        check("t5_err", err_nogrant, 4'b1000);
        repeat (3) step(4'h0, 8'h00, 4'h0, 4'h0, 4'hF);
        check("t5_err_sticky", err_nogrant, 4'b1000);

        // Reset mid-packet: input 0 on output 2.
        step(4'b0001, 8'h02, 4'h0, 4'h0, 4'hF);
        step(4'h0, 8'h02, 4'b0001, 4'h0, 4'hF);
        check("t6_busy_pre", out_busy, 4'b0100);
        do_reset("midrst");

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            g  = m_gnt();
            rv = 4'($urandom);
            bv = '0;
            bl = '0;
            for (int i = 0; i < 4; i++) begin
                if (g[i]) begin
                    bv[i] = ($urandom_range(9) < 7);
                    bl[i] = ($urandom_range(3) == 0);
                end else begin
                    bv[i] = ($urandom_range(63) == 0);
                    bl[i] = 1'($urandom);
                end
            end
            if ((n / 50) % 3 == 2) rdy = ($urandom_range(9) == 0) ? 4'($urandom) : 4'h0;
            else                   rdy = 4'($urandom);
            step(rv, 8'($urandom), bv, bl, rdy);
        end
        @(negedge clk);
        #1;
        check("drain_snap", exp_q.size(), 0);
        for (int o = 0; o < 4; o++) check("drain_grant", grant_q[o].size(), 0);

        do_reset("endrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
